ram_n: RTL and testbench

//   Parametrised word-addressed RAM: DEPTH words of WIDTH bits, one write port
//   and one combinational read port (Hack RAMn semantics).

---
 rtl/ram_n.sv | 53 +++++
 tb/tb_ram_n.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_n.sv
// ram_n: word-addressed RAM of 2**ADDR_W words by WIDTH bits.
// It has one write port and one combinational read port.
// Optional feature macro RAM_N_DUAL_READ_EN adds a second combinational read
// port (addr2/out2).
// Reset is synchronous and active-high, and it clears every word.
// Reset takes priority over a write in the same cycle.
module ram_n #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] addr,
    input  logic              load,
`ifdef RAM_N_DUAL_READ_EN
    input  logic [ADDR_W-1:0] addr2,
    output logic [WIDTH-1:0]  out2,
`endif
    output logic [WIDTH-1:0]  out
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Next contents: hold every word, replace only the addressed one on load
    always_comb begin
        mem_d = mem_q;
        if (load) begin
            mem_d[addr] = in;
        end
    end

    // Storage registers; reset wins over any write in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read straight from stored contents, so a same-cycle write shows only after the edge
    assign out = mem_q[addr];

`ifdef RAM_N_DUAL_READ_EN
    // Independent second read port with the same old-data-until-edge behaviour
    assign out2 = mem_q[addr2];
`endif

endmodule

// File: tb/tb_ram_n.sv
// tb_ram_n: directed and random test of ram_n.
// It checks two instances against a reference array model:
//   - the default configuration (16-bit words, depth 8)
//   - a sweep configuration (8-bit words, depth 64)
module tb_ram_n;

    logic        clk;
    logic        rst;
    logic [15:0] in_a;
    logic [2:0]  addr_a;
    logic        load_a;
    logic [15:0] out_a;
    logic [7:0]  in_b;
    logic [5:0]  addr_b;
    logic        load_b;
    logic [7:0]  out_b;
`ifdef RAM_N_DUAL_READ_EN
    logic [2:0]  addr2_a;
    logic [15:0] out2_a;
    logic [5:0]  addr2_b;
    logic [7:0]  out2_b;
`endif

    int checks;
    int errors;
    bit checking;

    // reference contents
    logic [15:0] m_a [8];
    logic [7:0]  m_b [64];

    ram_n #(.WIDTH(16), .ADDR_W(3)) u_ram8 (
        .clk  (clk),
        .rst  (rst),
        .in   (in_a),
        .addr (addr_a),
        .load (load_a),
`ifdef RAM_N_DUAL_READ_EN
        .addr2(addr2_a),
        .out2 (out2_a),
`endif
        .out  (out_a)
    );

    ram_n #(.WIDTH(8), .ADDR_W(6)) u_ram64 (
        .clk  (clk),
        .rst  (rst),
        .in   (in_b),
        .addr (addr_b),
        .load (load_b),
`ifdef RAM_N_DUAL_READ_EN
        .addr2(addr2_b),
        .out2 (out2_b),
`endif
        .out  (out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory is an array; reset zeroes it, load stores a word
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) m_a[i] = 16'h0000;
            for (int i = 0; i < 64; i++) m_b[i] = 8'h00;
        end else begin
            if (load_a) m_a[addr_a] = in_a;
            if (load_b) m_b[addr_b] = in_b;
        end
    end

    // Per-cycle comparison of every read port against the model
    always @(negedge clk) begin
        if (checking) begin
            check("cyc_out_a", out_a, m_a[addr_a]);
            check("cyc_out_b", 16'(out_b), 16'(m_b[addr_b]));
`ifdef RAM_N_DUAL_READ_EN
            check("cyc_out2_a", out2_a, m_a[addr2_a]);
            check("cyc_out2_b", 16'(out2_b), 16'(m_b[addr2_b]));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        checking = 1'b0;
        rst      = 1'b1;
        in_a     = 16'h0;
        addr_a   = 3'd0;
        load_a   = 1'b0;
        in_b     = 8'h0;
        addr_b   = 6'd0;
        load_b   = 1'b0;
`ifdef RAM_N_DUAL_READ_EN
        addr2_a  = 3'd0;
        addr2_b  = 6'd0;
`endif

        // 1. reset clears everything
        step();
        rst = 1'b0;
        checking = 1'b1;
        for (int a = 0; a < 8; a++) begin
            addr_a = 3'(a);
            #1;
            check("reset_zero", out_a, 16'h0000);
        end

        // 2. write timing: old value before the edge, new value after
        step();
        addr_a = 3'd3;
        in_a   = 16'h1234;
        load_a = 1'b1;
        #1;
        check("wr_before_edge", out_a, 16'h0000);
        step();
        load_a = 1'b0;
        check("wr_after_edge", out_a, 16'h1234);
        addr_a = 3'd2;
        #1;
        check("wr_neighbour_2", out_a, 16'h0000);
        addr_a = 3'd4;
        #1;
        check("wr_neighbour_4", out_a, 16'h0000);

        // 3. fill, read back, then idle edges with junk data must not write
        step();
        for (int i = 0; i < 8; i++) begin
            addr_a = 3'(i);
            in_a   = 16'hA000 + 16'(i);
            load_a = 1'b1;
            step();
        end
        load_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addr_a = 3'(i);
            #1;
            check("fill_read", out_a, 16'hA000 + 16'(i));
        end
        step();
        in_a = 16'hFFFF;
        for (int k = 0; k < 3; k++) begin
            addr_a = 3'(k * 3);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            addr_a = 3'(i);
            #1;
            check("noload_hold", out_a, 16'hA000 + 16'(i));
        end

        // 4. reset beats a simultaneous write
        step();
        rst    = 1'b1;
        load_a = 1'b1;
        addr_a = 3'd5;
        in_a   = 16'hBEEF;
        #1;
        check("rst_before_edge", out_a, 16'hA005);
        step();
        rst    = 1'b0;
        load_a = 1'b0;
        for (int a = 0; a < 8; a++) begin
            addr_a = 3'(a);
            #1;
            check("rst_over_write", out_a, 16'h0000);
        end

        // 5. 8-bit x 64 instance: boundary addresses, then random traffic
        step();
        addr_b = 6'd63;
        in_b   = 8'h5A;
        load_b = 1'b1;
        step();
        addr_b = 6'd0;
        in_b   = 8'hA5;
        step();
        load_b = 1'b0;
        addr_b = 6'd63;
        #1;
        check("b_addr63", 16'(out_b), 16'h005A);
        addr_b = 6'd0;
        #1;
        check("b_addr0", 16'(out_b), 16'h00A5);
        addr_b = 6'd31;
        #1;
        check("b_addr31", 16'(out_b), 16'h0000);

        for (int n = 0; n < 1000; n++) begin
            step();
            addr_a = 3'($urandom_range(0, 7));
            in_a   = 16'($urandom);
            load_a = 1'($urandom_range(0, 1));
            addr_b = 6'($urandom_range(0, 63));
            in_b   = 8'($urandom);
            load_b = 1'($urandom_range(0, 1));
`ifdef RAM_N_DUAL_READ_EN
            addr2_a = 3'($urandom_range(0, 7));
            addr2_b = 6'($urandom_range(0, 63));
`endif
        end
        step();
        load_a = 1'b0;
        load_b = 1'b0;

`ifdef RAM_N_DUAL_READ_EN
        // 6. second read port, including read-during-write on it
        addr_a = 3'd1;
        in_a   = 16'h1111;
        load_a = 1'b1;
        step();
        addr_a = 3'd6;
        in_a   = 16'h6666;
        step();
        load_a  = 1'b0;
        addr_a  = 3'd1;
        addr2_a = 3'd6;
        #1;
        check("dual_out", out_a, 16'h1111);
        check("dual_out2", out2_a, 16'h6666);
        step();
        addr_a = 3'd6;
        in_a   = 16'h7777;
        load_a = 1'b1;
        #1;
        check("dual_out2_before", out2_a, 16'h6666);
        step();
        load_a = 1'b0;
        check("dual_out2_after", out2_a, 16'h7777);
        check("dual_same_addr", out_a, out2_a);
        step();
`endif

        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
